hawk_axi_wr_arb: RTL and testbench
==================================

# hawk_axi_wr_arb

Arbiter and sequencer that shares the single hawk_axi_wr_master write port between several HAWK write requesters: page-write manager, ATT init/update, and list init/update. Requesters present axi_wr_reqpkt_t packets; the block grants one requester at a time. It forwards that requester's address and data channels independently, waits for the write response, and routes it back before re-arbitrating. It sits between the HAWK table/page managers and hawk_axi_wr_master.

## Interface
- NUM_REQ, default 3: number of requesters, legal 2..4; index 0 = pgwr_mngr, 1 = ATT writer, 2 = list writer.
- clk  input  1: clock, all state on rising edge.
- rst_n  input  1: reset, asynchronous, active-low.
- req_pkt_i  input  NUM_REQ x axi_wr_reqpkt_t: per-requester packet (addr, data, strb, awvalid, wvalid).
- req_rdy_o  output  NUM_REQ x axi_wr_rdypkt_t: per-requester awready/wready.
- req_resp_o  output  NUM_REQ x axi_wr_resppkt_t: per-requester bresp, one-cycle pulse = response.
- mst_pkt_o  output  axi_wr_reqpkt_t: packet to hawk_axi_wr_master.
- mst_rdy_i  input  axi_wr_rdypkt_t: awready/wready from master.
- mst_resp_i  input  axi_wr_resppkt_t: bresp pulse from master, 1 = write response received.
- gnt_idx_o  output  2: current/last granted requester index.
- busy_o  output  1: 1 when state != IDLE.
- proto_err_o  output  1: sticky, bresp seen outside WAIT_B.

## Operation
- States: IDLE, XFER, WAIT_B.
- A requester is pending when awvalid | wvalid.
- IDLE:
  - mst_pkt_o is all-zero.
  - All req_rdy_o and req_resp_o are 0.
  - If any requester is pending, choose the winner, register it into gnt_idx_o, clear aw_done/w_done, and go to XFER.
- XFER:
  - mst_pkt_o.addr/data/strb = req_pkt_i[gnt].
  - mst_pkt_o.awvalid = req awvalid & ~aw_done.
  - mst_pkt_o.wvalid = req wvalid & ~w_done.
  - req_rdy_o[gnt] = mst_rdy_i masked by the same done flags; all other requesters see 0.
  - aw_done sets on forwarded awvalid & awready; w_done sets on forwarded wvalid & wready.
  - When both handshakes are complete (already done or completing this cycle, including both in the same cycle), go to WAIT_B.
  - Channels complete in either order; no timeout.
- WAIT_B:
  - mst_pkt_o valids are 0.
  - On mst_resp_i.bresp = 1, drive req_resp_o[gnt].bresp = 1 combinationally the same cycle, then go to IDLE.
  - Round-robin pointer updates to (gnt+1) mod NUM_REQ.
- bresp in IDLE or XFER is ignored for routing and sets proto_err_o; only reset clears proto_err_o.
- Requester changes while granted are not checked; requesters hold their packet until handshake (AXI rule).

## Timing
- Reset (async assert): state = IDLE, gnt_idx_o = 0, pointer = 0, done flags = 0, proto_err_o = 0, busy_o = 0; all packet/rdy/resp outputs are 0. Reset mid-transaction abandons it with no response pulse.
- Arbitration latency: request seen in IDLE at cycle N; forwarded on mst_pkt_o at cycle N+1.
- Minimum transaction: IDLE (N), XFER with both ready (N+1), WAIT_B with bresp (N+2), IDLE (N+3). Next arbitration occurs at N+3, so there is one idle cycle between grants.
- Readies and bresp pass combinationally from master to the granted requester (no added latency).
- Round-robin search starts at the pointer and wraps from NUM_REQ-1 to 0.

## Configuration
- HAWK_WRARB_RR_EN defined: round-robin arbitration as above.
- HAWK_WRARB_RR_EN undefined: fixed priority, lowest pending index wins; the pointer is not implemented and starvation of high indices is permitted.

## Test plan
- Single request: req0 awvalid=wvalid=1, addr=0xFFF6100000-0x40, awready=wready=1 in the first XFER cycle, bresp 2 cycles later -> forwarded addr matches; req_rdy_o[0] = 2'b11 for one cycle; req_resp_o[0] pulses the same cycle as bresp; busy_o high for exactly 3 cycles (XFER+WAIT_B, until bresp).
- Split channels: wready arrives 3 cycles before awready -> wvalid drops after its handshake; WAIT_B entered only after awready; exactly one aw and one w handshake on the master.
- Round robin (RR_EN): req0, req1, req2 continuously pending -> grant order 0,1,2,0; with the macro undefined -> grant order 0,0,0.
- Isolation: req1 pending while req0 granted -> req_rdy_o[1] and req_resp_o[1] stay 0 until req1 is granted; no bresp reaches req1.
- Protocol error: bresp pulsed in IDLE -> proto_err_o = 1 and stays set; no req_resp_o pulse.
- Reset mid-op: rst_n low during WAIT_B -> all outputs 0 immediately; after release, a pending req1 (pointer=0, req0 idle) is granted at the next edge.

Source files
------------

// File: rtl/hawk_axi_wr_arb.sv
// hawk_axi_wr_arb: shares the single hawk_axi_wr_master write port between
// the HAWK write requesters (0 = pgwr_mngr, 1 = ATT writer, 2 = list writer).
// One requester is granted at a time. Its AW and W channels are forwarded
// independently. The write response is routed back before re-arbitration.
// Optional feature macro: HAWK_WRARB_RR_EN selects round-robin arbitration.
// When it is undefined, arbitration is fixed priority and the lowest pending
// index wins.
//
// Handshake rule on every channel: a transfer happens in the cycle where
// valid and ready are both 1. A source holds valid and its payload until
// that cycle. Ready may depend combinationally on valid.

package hawk_axi_wr_pkg;
    localparam int AXI_ADDR_W = 40;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  awvalid;
        logic                  wvalid;
    } axi_wr_reqpkt_t;

    typedef struct packed {
        logic awready;
        logic wready;
    } axi_wr_rdypkt_t;

    typedef struct packed {
        logic bresp;
    } axi_wr_resppkt_t;
endpackage

module hawk_axi_wr_arb
    import hawk_axi_wr_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  axi_wr_reqpkt_t  req_pkt_i  [NUM_REQ],
    output axi_wr_rdypkt_t  req_rdy_o  [NUM_REQ],
    output axi_wr_resppkt_t req_resp_o [NUM_REQ],
    output axi_wr_reqpkt_t  mst_pkt_o,
    input  axi_wr_rdypkt_t  mst_rdy_i,
    input  axi_wr_resppkt_t mst_resp_i,
    output logic [1:0]      gnt_idx_o,
    output logic            busy_o,
    output logic            proto_err_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, WAIT_B = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [1:0]     gnt_q;
    logic           aw_done, w_done;
    logic           proto_err_q;
    logic [NUM_REQ-1:0] pending;
    logic           any_pend;
    logic [1:0]     win_idx;
    axi_wr_reqpkt_t sel_pkt;
    logic           aw_hs, w_hs, aw_fin, w_fin;

    // Pending vector: a requester wants the port when either channel is valid.
    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            pending[j] = req_pkt_i[j].awvalid | req_pkt_i[j].wvalid;
        end
        any_pend = |pending;
    end

`ifdef HAWK_WRARB_RR_EN
    logic [1:0] rr_ptr;
    logic [2:0] cand;
    logic       found;

    // Round-robin winner: search upward from the pointer and wrap at NUM_REQ-1.
    always_comb begin
        win_idx = rr_ptr;
        found   = 1'b0;
        cand    = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && cand == 3'(j) && pending[j]) begin
                    found   = 1'b1;
                    win_idx = 2'(j);
                end
            end
        end
    end

    // Pointer moves past the requester whose response was just delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 2'd0;
        end else if (state_q == WAIT_B && mst_resp_i.bresp) begin
            rr_ptr <= (gnt_q == 2'(NUM_REQ - 1)) ? 2'd0 : gnt_q + 2'd1;
        end
    end
`else
    logic found;

    // Fixed priority winner: the lowest pending index wins.
    always_comb begin
        win_idx = 2'd0;
        found   = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && pending[j]) begin
                found   = 1'b1;
                win_idx = 2'(j);
            end
        end
    end
`endif

    // Mux the granted requester's packet, and detect handshakes on the forwarded channels.
    always_comb begin
        sel_pkt = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt_q == 2'(j)) begin
                sel_pkt = req_pkt_i[j];
            end
        end
        aw_hs  = (state_q == XFER) && sel_pkt.awvalid && !aw_done && mst_rdy_i.awready;
        w_hs   = (state_q == XFER) && sel_pkt.wvalid && !w_done && mst_rdy_i.wready;
        aw_fin = aw_done | aw_hs;
        w_fin  = w_done | w_hs;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_pend)          state_d = XFER;
            XFER:    if (aw_fin && w_fin)   state_d = WAIT_B;
            WAIT_B:  if (mst_resp_i.bresp)  state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Grant register, per-channel done flags and sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= 2'd0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (state_q == IDLE && any_pend) begin
                gnt_q   <= win_idx;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (state_q == XFER) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (mst_resp_i.bresp && state_q != WAIT_B) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // Output logic: forward the granted requester and route readies and the response.
    always_comb begin
        mst_pkt_o = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            req_rdy_o[j]  = '0;
            req_resp_o[j] = '0;
        end
        case (state_q)
            XFER: begin
                mst_pkt_o.addr    = sel_pkt.addr;
                mst_pkt_o.data    = sel_pkt.data;
                mst_pkt_o.strb    = sel_pkt.strb;
                mst_pkt_o.awvalid = sel_pkt.awvalid & ~aw_done;
                mst_pkt_o.wvalid  = sel_pkt.wvalid & ~w_done;
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (gnt_q == 2'(j)) begin
                        req_rdy_o[j].awready = mst_rdy_i.awready & ~aw_done;
                        req_rdy_o[j].wready  = mst_rdy_i.wready & ~w_done;
                    end
                end
            end
            WAIT_B: begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (gnt_q == 2'(j)) begin
                        req_resp_o[j].bresp = mst_resp_i.bresp;
                    end
                end
            end
            default: ;
        endcase
    end

    assign gnt_idx_o   = gnt_q;
    assign busy_o      = (state_q != IDLE);
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_hawk_axi_wr_arb.sv
// Bench for hawk_axi_wr_arb. Inputs change on the falling edge, and outputs
// are sampled 1 ns later. Expected forwarded addresses and grant indices
// are queued when a request is driven. They are popped when the master side
// sees the transaction.
module tb_hawk_axi_wr_arb;
    import hawk_axi_wr_pkg::*;

    localparam int NREQ = 3;
    localparam logic [39:0] ADDR0 = 40'hFFF6100000 - 40'h40;
    localparam logic [39:0] ADDR1 = 40'h0012345680;
    localparam logic [39:0] ADDR2 = 40'h000ABCDE00;

    logic            clk = 1'b0;
    logic            rst_n;
    axi_wr_reqpkt_t  req_pkt  [NREQ];
    axi_wr_rdypkt_t  req_rdy  [NREQ];
    axi_wr_resppkt_t req_resp [NREQ];
    axi_wr_reqpkt_t  mst_pkt;
    axi_wr_rdypkt_t  mst_rdy;
    axi_wr_resppkt_t mst_resp;
    logic [1:0]      gnt_idx;
    logic            busy;
    logic            proto_err;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [39:0] exp_q[$];
    logic [1:0]  exp_gnt_q[$];

    typedef struct {
        logic [39:0]     addr;
        int              n_aw;
        int              n_w;
        int              awv_cyc;
        int              wv_cyc;
        int              busy_cyc;
        int              rdy11;
        int              iso_viol;
        logic [NREQ-1:0] resp_bits;
        logic [1:0]      gnt;
        bit              to;
    } obs_t;

    hawk_axi_wr_arb #(.NUM_REQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_pkt_i  (req_pkt),
        .req_rdy_o  (req_rdy),
        .req_resp_o (req_resp),
        .mst_pkt_o  (mst_pkt),
        .mst_rdy_i  (mst_rdy),
        .mst_resp_i (mst_resp),
        .gnt_idx_o  (gnt_idx),
        .busy_o     (busy),
        .proto_err_o(proto_err)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        for (int i = 0; i < NREQ; i++) req_pkt[i] = '0;
        mst_rdy  = '0;
        mst_resp = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [39:0] a);
        req_pkt[i].addr    = a;
        req_pkt[i].data    = {$urandom, $urandom};
        req_pkt[i].strb    = 8'($urandom_range(1, 255));
        req_pkt[i].awvalid = 1'b1;
        req_pkt[i].wvalid  = 1'b1;
    endtask

    // Master-side driver. It serves one transaction. x counts XFER cycles from 0.
    // awready and wready rise at aw_at and w_at. bresp pulses b_after cycles
    // after both handshakes. The granted requester drops its valids in the
    // bresp cycle unless keep is set.
    task automatic master_serve(input int aw_at, input int w_at, input int b_after,
                                input bit keep, output obs_t o);
        int x = -1;
        int b = 0;
        bit ph = 0;
        bit done = 0;
        o = '{default: 0};
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            mst_resp.bresp = 1'b0;
            if (busy) o.busy_cyc++;
            if (busy && !ph) x++;
            if (ph) b++;
            mst_rdy.awready = (x >= 0) && (x >= aw_at);
            mst_rdy.wready  = (x >= 0) && (x >= w_at);
            if (ph && b == b_after) mst_resp.bresp = 1'b1;
            #1;
            if (mst_pkt.awvalid) o.awv_cyc++;
            if (mst_pkt.wvalid)  o.wv_cyc++;
            if (mst_pkt.awvalid && mst_rdy.awready) begin
                o.n_aw++;
                o.addr = mst_pkt.addr;
            end
            if (mst_pkt.wvalid && mst_rdy.wready) o.n_w++;
            for (int i = 0; i < NREQ; i++) begin
                if (i == int'(gnt_idx)) begin
                    if ({req_rdy[i].awready, req_rdy[i].wready} == 2'b11) o.rdy11++;
                end else if (req_rdy[i] != '0 || req_resp[i].bresp) begin
                    o.iso_viol++;
                end
            end
            if (mst_resp.bresp) begin
                for (int i = 0; i < NREQ; i++) o.resp_bits[i] = req_resp[i].bresp;
                o.gnt = gnt_idx;
                if (!keep) begin
                    req_pkt[int'(gnt_idx)].awvalid = 1'b0;
                    req_pkt[int'(gnt_idx)].wvalid  = 1'b0;
                end
                mst_rdy = '0;
                done = 1;
            end else begin
                for (int i = 0; i < NREQ; i++) if (req_resp[i].bresp) o.iso_viol++;
            end
            if (!ph && o.n_aw > 0 && o.n_w > 0) ph = 1;
        end
        o.to = !done;
        if (done) begin
            @(posedge clk);
            #1;
            mst_resp.bresp = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [1:0] rdy_or;
        logic       resp_or;
        apply_reset();
        #1;
        rdy_or = '0;
        resp_or = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rdy_or  = rdy_or | req_rdy[i];
            resp_or = resp_or | req_resp[i].bresp;
        end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        vec_cnt++; if (gnt_idx !== 2'd0) begin err_cnt++; $display("FAIL reset_gnt: got %0d want 0", gnt_idx); end
        vec_cnt++; if (proto_err !== 1'b0) begin err_cnt++; $display("FAIL reset_proto: got %b want 0", proto_err); end
        vec_cnt++; if (mst_pkt !== '0) begin err_cnt++; $display("FAIL reset_mst_pkt: got %h want 0", mst_pkt); end
        vec_cnt++; if (rdy_or !== 2'b00 || resp_or !== 1'b0) begin err_cnt++; $display("FAIL reset_req_out: rdy %b resp %b want 0", rdy_or, resp_or); end
    endtask

    task automatic test_single();
        obs_t o;
        logic [39:0] ea;
        apply_reset();
        set_req(0, ADDR0);
        exp_q.push_back(ADDR0);
        master_serve(0, 0, 2, 1'b0, o);
        ea = exp_q.pop_front();
        vec_cnt++; if (o.to) begin err_cnt++; $display("FAIL single_timeout: no bresp cycle reached"); end
        vec_cnt++; if (o.addr !== ea) begin err_cnt++; $display("FAIL single_addr: got %h want %h", o.addr, ea); end
        vec_cnt++; if (o.rdy11 !== 1) begin err_cnt++; $display("FAIL single_rdy11: got %0d cycles want 1", o.rdy11); end
        vec_cnt++; if (o.resp_bits !== 3'b001 || o.iso_viol !== 0) begin err_cnt++; $display("FAIL single_resp: bits %b stray %0d want 001/0", o.resp_bits, o.iso_viol); end
        vec_cnt++; if (o.busy_cyc !== 3) begin err_cnt++; $display("FAIL single_busy_len: got %0d want 3", o.busy_cyc); end
        vec_cnt++; if (o.n_aw !== 1 || o.n_w !== 1) begin err_cnt++; $display("FAIL single_hs: aw %0d w %0d want 1/1", o.n_aw, o.n_w); end
        @(negedge clk); #1;
        vec_cnt++; if (busy !== 1'b0 || req_resp[0].bresp !== 1'b0) begin err_cnt++; $display("FAIL single_after: busy %b resp %b want 0/0", busy, req_resp[0].bresp); end
    endtask

    task automatic test_split();
        obs_t o;
        logic [39:0] ea;
        apply_reset();
        set_req(2, ADDR2);
        exp_q.push_back(ADDR2);
        master_serve(3, 0, 1, 1'b0, o);
        ea = exp_q.pop_front();
        vec_cnt++; if (o.addr !== ea) begin err_cnt++; $display("FAIL split_addr: got %h want %h", o.addr, ea); end
        vec_cnt++; if (o.n_aw !== 1 || o.n_w !== 1) begin err_cnt++; $display("FAIL split_hs: aw %0d w %0d want 1/1", o.n_aw, o.n_w); end
        vec_cnt++; if (o.wv_cyc !== 1 || o.awv_cyc !== 4) begin err_cnt++; $display("FAIL split_valids: wv %0d awv %0d want 1/4", o.wv_cyc, o.awv_cyc); end
        vec_cnt++; if (o.busy_cyc !== 5) begin err_cnt++; $display("FAIL split_busy_len: got %0d want 5", o.busy_cyc); end
        vec_cnt++; if (o.resp_bits !== 3'b100) begin err_cnt++; $display("FAIL split_resp: got %b want 100", o.resp_bits); end
    endtask

    task automatic test_arb_order();
        obs_t o;
        int n;
        logic [39:0] ea;
        logic [1:0]  eg;
        apply_reset();
        set_req(0, ADDR0);
        set_req(1, ADDR1);
        set_req(2, ADDR2);
`ifdef HAWK_WRARB_RR_EN
        exp_q.push_back(ADDR0); exp_gnt_q.push_back(2'd0);
        exp_q.push_back(ADDR1); exp_gnt_q.push_back(2'd1);
        exp_q.push_back(ADDR2); exp_gnt_q.push_back(2'd2);
        exp_q.push_back(ADDR0); exp_gnt_q.push_back(2'd0);
`else
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(ADDR0); exp_gnt_q.push_back(2'd0);
        end
`endif
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            master_serve($urandom_range(0, 1), $urandom_range(0, 1), 1, 1'b1, o);
            ea = exp_q.pop_front();
            eg = exp_gnt_q.pop_front();
            vec_cnt++; if (o.gnt !== eg || o.addr !== ea) begin err_cnt++; $display("FAIL arb_order_%0d: gnt %0d addr %h want %0d %h", k, o.gnt, o.addr, eg, ea); end
        end
    endtask

    task automatic test_isolation();
        obs_t o;
        logic [39:0] ea;
        apply_reset();
        set_req(0, ADDR0);
        set_req(1, ADDR1);
        exp_q.push_back(ADDR0);
        exp_q.push_back(ADDR1);
        master_serve(1, 2, 2, 1'b0, o);
        ea = exp_q.pop_front();
        vec_cnt++; if (o.addr !== ea || o.resp_bits !== 3'b001 || o.iso_viol !== 0) begin err_cnt++; $display("FAIL iso_first: addr %h bits %b viol %0d want %h 001 0", o.addr, o.resp_bits, o.iso_viol, ea); end
        master_serve(0, 1, 1, 1'b0, o);
        ea = exp_q.pop_front();
        vec_cnt++; if (o.addr !== ea || o.resp_bits !== 3'b010 || o.iso_viol !== 0 || o.gnt !== 2'd1) begin err_cnt++; $display("FAIL iso_second: addr %h bits %b viol %0d gnt %0d want %h 010 0 1", o.addr, o.resp_bits, o.iso_viol, o.gnt, ea); end
    endtask

    task automatic test_proto_err();
        logic resp_or;
        apply_reset();
        @(negedge clk);
        mst_resp.bresp = 1'b1;
        #1;
        resp_or = 1'b0;
        for (int i = 0; i < NREQ; i++) resp_or = resp_or | req_resp[i].bresp;
        vec_cnt++; if (resp_or !== 1'b0) begin err_cnt++; $display("FAIL proto_no_route: got %b want 0", resp_or); end
        @(negedge clk);
        mst_resp.bresp = 1'b0;
        #1;
        vec_cnt++; if (proto_err !== 1'b1) begin err_cnt++; $display("FAIL proto_set: got %b want 1", proto_err); end
        repeat (3) @(negedge clk);
        #1;
        vec_cnt++; if (proto_err !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL proto_sticky: err %b busy %b want 1/0", proto_err, busy); end
    endtask

    task automatic test_reset_mid_op();
        logic [1:0] rdy_or;
        logic       resp_or;
        apply_reset();
        set_req(0, ADDR0);
        mst_rdy = 2'b11;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        vec_cnt++; if (busy !== 1'b1 || mst_pkt.awvalid !== 1'b0 || mst_pkt.wvalid !== 1'b0) begin err_cnt++; $display("FAIL midop_waitb: busy %b awv %b wv %b want 1 0 0", busy, mst_pkt.awvalid, mst_pkt.wvalid); end
        rst_n = 1'b0;
        mst_resp.bresp = 1'b1;
        #1;
        rdy_or = '0;
        resp_or = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rdy_or  = rdy_or | req_rdy[i];
            resp_or = resp_or | req_resp[i].bresp;
        end
        vec_cnt++; if (busy !== 1'b0 || gnt_idx !== 2'd0 || mst_pkt !== '0 || rdy_or !== 2'b00 || resp_or !== 1'b0) begin err_cnt++; $display("FAIL midop_reset_outs: busy %b gnt %0d pkt %h rdy %b resp %b want all 0", busy, gnt_idx, mst_pkt, rdy_or, resp_or); end
        mst_resp.bresp = 1'b0;
        req_pkt[0] = '0;
        set_req(1, ADDR1);
        mst_rdy = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        vec_cnt++; if (gnt_idx !== 2'd1 || busy !== 1'b1 || mst_pkt.awvalid !== 1'b1 || mst_pkt.addr !== ADDR1) begin err_cnt++; $display("FAIL midop_regrant: gnt %0d busy %b awv %b addr %h want 1 1 1 %h", gnt_idx, busy, mst_pkt.awvalid, mst_pkt.addr, ADDR1); end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_split();
        test_arb_order();
        test_isolation();
        test_proto_err();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
